// File: rtl/qnigma_poly1305_mac.sv
// Streaming Poly1305 authenticator: gathers 16-byte blocks, drives the shared
// field ALU for acc = (acc + blk) * r mod 2^130-5, and emits acc + s as the tag.
module qnigma_poly1305_mac #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   din,
    input  logic         vin,
    input  logic         sof,
    input  logic         eof,
    output logic         cts,
    output logic         lst,
    input  logic [255:0] key,
    output logic [W-1:0] alu_opa,
    output logic [W-1:0] alu_opb,
    output logic         alu_add,
    output logic         alu_mul,
    output logic         alu_cal,
    input  logic [W-1:0] alu_res,
    input  logic         alu_rdy,
    output logic [127:0] tag,
    output logic         tag_val
);
    localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;

    typedef enum logic [1:0] {COLLECT, ADD, MUL, FINAL} state_t;

    state_t         state;
    state_t         nxt;
    logic [4:0]     cnt;
    logic [127:0]   data;
    logic [W-1:0]   acc;
    logic [W-1:0]   tmp;
    logic [127:0]   r;
    logic [127:0]   s;
    logic           last;
    logic           pend;
    logic [127:0]   r_raw;
    logic [127:0]   r_key;
    logic [127:0]   s_key;
    logic [127:0]   sum;
    logic [127:0]   tag_nx;
    logic [128:0]   blk;
    logic [3:0]     pos;
    logic           take;
    logic           done;
    logic           rdy_ok;

    always_comb begin
        r_raw  = '0;
        s_key  = '0;
        tag_nx = '0;
        for (int i = 0; i < 16; i++) begin
            r_raw[8*i +: 8]       = key[255-8*i -: 8];
            s_key[8*i +: 8]       = key[127-8*i -: 8];
            tag_nx[127-8*i -: 8]  = sum[8*i +: 8];
        end
    end

    assign r_key  = r_raw & CLAMP;
    assign sum    = acc[127:0] + s;
    assign take   = (state == COLLECT) && vin;
    assign pos    = sof ? 4'd0 : cnt[3:0];
    assign done   = take && (pos == 4'd15 || eof);
    assign lst    = done;
    assign cts    = (state == COLLECT);
    assign rdy_ok = alu_rdy && pend;
    // cnt holds the byte count n here, so the pad lands at bit 8n
    assign blk    = {1'b0, data} | (129'd1 << {cnt, 3'b000});

    always_comb begin
        nxt     = state;
        alu_cal = 1'b0;
        alu_add = 1'b0;
        alu_mul = 1'b0;
        alu_opa = '0;
        alu_opb = '0;
        unique case (state)
            COLLECT: begin
                if (done) nxt = ADD;
            end
            ADD: begin
                alu_add = 1'b1;
                alu_cal = !pend;
                alu_opa = acc;
                alu_opb = {{(W-129){1'b0}}, blk};
                if (rdy_ok) nxt = MUL;
            end
            MUL: begin
                alu_mul = 1'b1;
                alu_cal = !pend;
                alu_opa = tmp;
                alu_opb = {{(W-128){1'b0}}, r};
                if (rdy_ok) nxt = last ? FINAL : COLLECT;
            end
            FINAL: begin
                nxt = COLLECT;
            end
            default: begin
                nxt = COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= COLLECT;
            cnt     <= '0;
            data    <= '0;
            acc     <= '0;
            tmp     <= '0;
            r       <= '0;
            s       <= '0;
            last    <= 1'b0;
            pend    <= 1'b0;
            tag     <= '0;
            tag_val <= 1'b0;
        end else begin
            state   <= nxt;
            tag_val <= 1'b0;
            if (alu_cal) pend <= 1'b1;
            else if (rdy_ok) pend <= 1'b0;
            if (take) begin
                if (sof) begin
                    acc  <= '0;
                    r    <= r_key;
                    s    <= s_key;
                    data <= {120'b0, din};
                    cnt  <= 5'd1;
                end else begin
                    data[{pos, 3'b000} +: 8] <= din;
                    cnt <= cnt + 5'd1;
                end
                if (done) last <= eof;
            end
            if (state == ADD && rdy_ok) tmp <= alu_res;
            if (state == MUL && rdy_ok) begin
                acc  <= alu_res;
                cnt  <= '0;
                data <= '0;
            end
            if (state == FINAL) begin
                tag     <= tag_nx;
                tag_val <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_qnigma_poly1305_mac.sv
// Directed bench for qnigma_poly1305_mac with a behavioural F1305 ALU of
// programmable latency and a cts-paced byte source.
module tb_qnigma_poly1305_mac;
    localparam int W = 256;
    localparam logic [255:0] K1 =
        256'h85d6be7857556d337f4452fe42d506a80103808afb0db2fd4abff6af4149f51b;
    localparam logic [127:0] T1 = 128'ha8061dc1305136c6c22b8baf0c0127a9;
    localparam logic [255:0] K4 = {128'h0, 128'h101112131415161718191a1b1c1d1e1f};
    localparam logic [127:0] T4 = 128'h101112131415161718191a1b1c1d1e1f;

    logic         clk = 0;
    logic         rst = 0;
    logic [7:0]   din = 0;
    logic         vin = 0;
    logic         sof = 0;
    logic         eof = 0;
    logic         cts;
    logic         lst;
    logic [255:0] key = 0;
    logic [W-1:0] alu_opa;
    logic [W-1:0] alu_opb;
    logic         alu_add;
    logic         alu_mul;
    logic         alu_cal;
    logic [W-1:0] alu_res = 0;
    logic         alu_rdy = 0;
    logic [127:0] tag;
    logic         tag_val;

    int n_chk = 0;
    int n_err = 0;
    int lat = 1;
    int tv_cnt = 0;
    int busy_viol = 0;
    int op_viol = 0;
    int lst_q[$];
    logic [127:0] tag_q[$];
    logic [7:0] mb [0:63];
    string v1 = "Cryptographic Forum Research Group";

    qnigma_poly1305_mac #(.W(W)) dut (
        .clk(clk), .rst(rst), .din(din), .vin(vin), .sof(sof), .eof(eof),
        .cts(cts), .lst(lst), .key(key),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_add(alu_add),
        .alu_mul(alu_mul), .alu_cal(alu_cal), .alu_res(alu_res),
        .alu_rdy(alu_rdy), .tag(tag), .tag_val(tag_val)
    );

    always #5 clk = ~clk;

    // reference field ALU: result reduced mod 2^130-5 after lat cycles
    always begin
        logic [511:0] a, b, p, res;
        if (alu_cal === 1'b1) begin
            p = (512'd1 << 130) - 512'd5;
            a = 512'(alu_opa);
            b = 512'(alu_opb);
            res = alu_mul ? (a * b) % p : (a + b) % p;
            repeat (lat) @(negedge clk);
            alu_res = res[255:0];
            alu_rdy = 1'b1;
            @(negedge clk);
            alu_rdy = 1'b0;
        end else begin
            @(negedge clk);
        end
    end

    always @(negedge clk) begin
        if (tag_val === 1'b1) begin
            tv_cnt++;
            tag_q.push_back(tag);
        end
        if ((alu_add || alu_mul) && cts) busy_viol++;
        if (alu_cal && (alu_add == alu_mul)) op_viol++;
    end

    task automatic check(input string name, input logic [255:0] got,
                         input logic [255:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic load_v1();
        for (int i = 0; i < 34; i++) mb[i] = v1[i];
    endtask

    // sends bytes 0..stop-1 of an n-byte message; junk drives ignored bytes while cts=0
    task automatic send(input int n, input int stop, input logic [255:0] k,
                        input bit junk);
        int i = 0;
        int g = 0;
        key = k;
        while (i < stop && g < 20000) begin
            @(negedge clk);
            g++;
            if (cts) begin
                din = mb[i];
                vin = 1'b1;
                sof = (i == 0);
                eof = (i == n - 1);
                #1;
                if (lst) lst_q.push_back(i + 1);
                i++;
            end else if (junk) begin
                din = 8'hff;
                vin = 1'b1;
                sof = 1'b0;
                eof = 1'b1;
            end else begin
                vin = 1'b0;
                sof = 1'b0;
                eof = 1'b0;
            end
        end
        @(negedge clk);
        vin = 1'b0;
        sof = 1'b0;
        eof = 1'b0;
        check("send_timeout", 256'(g < 20000), 256'(1));
    endtask

    task automatic wait_tags(input int target);
        int g = 0;
        while (tv_cnt < target && g < 3000) begin
            @(negedge clk);
            g++;
        end
        check("tag_timeout", 256'(tv_cnt >= target), 256'(1));
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int base;
        repeat (3) @(negedge clk);
        check("rst_cts", 256'(cts), 256'(1));
        check("rst_lst", 256'(lst), 256'(0));
        check("rst_alu", 256'({alu_cal, alu_add, alu_mul}), 256'(0));
        check("rst_opa", alu_opa, 256'(0));
        check("rst_tag", 256'({tag_val, tag}), 256'(0));
        rst = 1;
        @(negedge clk);

        // RFC 8439 vector, lst positions and busy handshake
        load_v1();
        lst_q.delete();
        base = tv_cnt;
        send(34, 34, K1, 0);
        wait_tags(base + 1);
        check("v1_tag", 256'(tag), 256'(T1));
        check("v1_pulses", 256'(tv_cnt - base), 256'(1));
        check("v1_lst_n", 256'(lst_q.size()), 256'(3));
        if (lst_q.size() == 3) begin
            check("v1_lst0", 256'(lst_q[0]), 256'(16));
            check("v1_lst1", 256'(lst_q[1]), 256'(32));
            check("v1_lst2", 256'(lst_q[2]), 256'(34));
        end

        // zero key -> zero tag
        base = tv_cnt;
        send(20, 20, 256'h0, 0);
        wait_tags(base + 1);
        check("zkey_tag", 256'(tag), 256'(0));

        // r = 0: tag = s; 16-byte message takes exactly one block
        for (int i = 0; i < 16; i++) mb[i] = 8'(8'h40 + i);
        lst_q.delete();
        base = tv_cnt;
        send(16, 16, K4, 0);
        wait_tags(base + 1);
        check("r0_tag", 256'(tag), 256'(T4));
        check("r0_lst_n", 256'(lst_q.size()), 256'(1));
        check("r0_pulses", 256'(tv_cnt - base), 256'(1));

        // 1-byte message (sof & eof together)
        lst_q.delete();
        base = tv_cnt;
        send(1, 1, K4, 0);
        wait_tags(base + 1);
        check("one_tag", 256'(tag), 256'(T4));
        check("one_lst_n", 256'(lst_q.size()), 256'(1));

        // reset inside the second block, then a clean rerun
        load_v1();
        base = tv_cnt;
        send(34, 20, K1, 0);
        repeat (4) @(negedge clk);
        rst = 0;
        repeat (3) @(negedge clk);
        check("abort_tag", 256'(tag), 256'(0));
        check("abort_cts", 256'(cts), 256'(1));
        rst = 1;
        repeat (2) @(negedge clk);
        check("abort_nopulse", 256'(tv_cnt - base), 256'(0));
        send(34, 34, K1, 0);
        wait_tags(base + 1);
        check("rerun_tag", 256'(tag), 256'(T1));
        check("rerun_pulses", 256'(tv_cnt - base), 256'(1));

        // sof mid-message restarts from scratch
        base = tv_cnt;
        send(34, 10, K1, 0);
        send(34, 34, K1, 0);
        wait_tags(base + 1);
        check("restart_tag", 256'(tag), 256'(T1));
        check("restart_pulses", 256'(tv_cnt - base), 256'(1));

        // back-to-back messages at two ALU latencies, junk while cts=0
        for (int l = 0; l < 2; l++) begin
            lat = (l == 0) ? 20 : 1;
            tag_q.delete();
            base = tv_cnt;
            send(34, 34, K1, 1);
            send(34, 34, K1, 1);
            wait_tags(base + 2);
            check("b2b_pulses", 256'(tv_cnt - base), 256'(2));
            if (tag_q.size() == 2) begin
                check("b2b_tag0", 256'(tag_q[0]), 256'(T1));
                check("b2b_tag1", 256'(tag_q[1]), 256'(T1));
            end
        end

        check("cts_busy", 256'(busy_viol), 256'(0));
        check("alu_op_sel", 256'(op_viol), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
